pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 47 ++++
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer_ras_stack.sv | 55 +++++
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared definitions for the PC sequencer.
//   - branch-mode encodings for br_mode
//   - bit indices into the sticky err vector
//   - next-PC source enum
//   - target calculation and branch-condition helpers
package pc_sequencer_pkg;

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_BLT = 2'b10;
  localparam logic [1:0] BR_BGE = 2'b11;

  localparam int ERR_RET_UFLOW = 0;  // RET with empty return stack
  localparam int ERR_JB_BOTH   = 1;  // JUMP and BRANCH asserted together

  // Widest PC supported by the target helper; callers truncate the result.
  localparam int CALC_W = 64;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_RET,
    SRC_CALL,
    SRC_JUMP,
    SRC_BRANCH
  } npc_src_e;

  // pc_plus4 + (offset << 2). Low bits of the sum only depend on low bits
  // of the operands, so truncating to ADDR_W gives the modulo-2^ADDR_W result.
  function automatic logic [CALC_W-1:0] calc_target(input logic [CALC_W-1:0] pc_plus4,
                                                    input logic [CALC_W-1:0] ofs_sext);
    return pc_plus4 + (ofs_sext << 2);
  endfunction

  function automatic logic br_cond(input logic [1:0] mode, input logic zero, input logic neg);
    logic c;
    c = 1'b0;
    case (mode)
      BR_BEQ:  c = zero;
      BR_BNE:  c = ~zero;
      BR_BLT:  c = neg;
      BR_BGE:  c = ~neg;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and status outputs of the PC sequencer.
//   slave  : the sequencer (consumes controls, drives pc/status)
//   master : the instruction-decode side driving controls
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int OFS_W  = 8
);
  logic              stall;
  logic              jump;
  logic              branch;
  logic [1:0]        br_mode;
  logic              zero;
  logic              neg;
  logic              call;
  logic              ret;
  logic [OFS_W-1:0]  offset;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              taken;
  logic              ras_empty;
  logic              ras_full;
  logic [1:0]        err;

  modport slave (
    input  stall, jump, branch, br_mode, zero, neg, call, ret, offset,
    output pc, pc_plus4, taken, ras_empty, ras_full, err
  );

  modport master (
    output stall, jump, branch, br_mode, zero, neg, call, ret, offset,
    input  pc, pc_plus4, taken, ras_empty, ras_full, err
  );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, reset   : clock, synchronous active-high reset (clears occupancy only)
//   push, pop    : push push_data / pop top; both together replaces the top
//   top          : most recently pushed entry (valid when !empty)
//   empty, full  : occupancy flags
// A push while full overwrites the oldest entry and keeps the count at DEPTH.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr_q;  // next slot to write; top lives at wptr_q-1
  logic [CNT_W-1:0] cnt_q;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign top   = mem[wptr_q - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (push && pop) begin
      // replace in place: pointer and count unchanged
    end else if (push) begin
      wptr_q <= wptr_q + PTR_W'(1);
      if (!full) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wptr_q <= wptr_q - PTR_W'(1);
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  // Entry storage is never cleared; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      if (!empty) mem[wptr_q - PTR_W'(1)] <= push_data;
      else        mem[wptr_q]             <= push_data;
    end else if (push) begin
      mem[wptr_q] <= push_data;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with relative jump/branch, call/return stack.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, overrides stall
//   bus    : pc_sequencer_if.slave
//            in : stall, jump, branch, br_mode, zero, neg, call, ret, offset
//            out: pc (reg), pc_plus4 (comb), taken (reg), ras_empty, ras_full,
//                 err (sticky: [0] RET underflow, [1] JUMP+BRANCH)
// Next-PC priority: RET (stack non-empty) > CALL > JUMP > BRANCH-taken > PC+4.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              OFS_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);
  logic [ADDR_W-1:0] pc_q, pc_plus4, tgt, nxt_pc, ras_top;
  logic [CALC_W-1:0] ofs_sext;
  logic              taken_q;
  logic [1:0]        err_q, err_set;
  logic              ras_empty, ras_full;
  logic              do_push, do_pop;
  npc_src_e          src;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign ofs_sext = CALC_W'($signed(bus.offset));
  assign tgt      = ADDR_W'(calc_target(CALC_W'(pc_plus4), ofs_sext));

  always_comb begin
    src     = SRC_SEQ;
    nxt_pc  = pc_plus4;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = '0;
    // CALL+RET with a live stack only pops: the popped address wins and
    // nothing is pushed, so occupancy drops by one.
    if (bus.ret && !ras_empty) begin
      src    = SRC_RET;
      nxt_pc = ras_top;
      do_pop = 1'b1;
    end else if (bus.call) begin
      src     = SRC_CALL;
      nxt_pc  = tgt;
      do_push = 1'b1;
    end else if (bus.jump && !bus.branch) begin
      src    = SRC_JUMP;
      nxt_pc = tgt;
    end else if (bus.branch && !bus.jump && br_cond(bus.br_mode, bus.zero, bus.neg)) begin
      src    = SRC_BRANCH;
      nxt_pc = tgt;
    end
    if (bus.ret && ras_empty)
      err_set[ERR_RET_UFLOW] = 1'b1;
    if (bus.jump && bus.branch && !bus.call && !bus.ret)
      err_set[ERR_JB_BOTH] = 1'b1;
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push && !bus.stall),
    .pop       (do_pop && !bus.stall),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      err_q   <= '0;
    end else if (!bus.stall) begin
      pc_q    <= nxt_pc;
      taken_q <= (src != SRC_SEQ);
      err_q   <= err_q | err_set;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.taken     = taken_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32), .OFS_W(8)) bus ();

  pc_sequencer #(
    .ADDR_W(32), .OFS_W(8), .RAS_DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: PC, last-redirect flag, sticky errors, stack as a queue.
  logic [31:0] m_pc;
  logic        m_taken;
  logic [1:0]  m_err;
  logic [31:0] m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic compare();
    chk("pc", bus.pc, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("taken", 32'(bus.taken), 32'(m_taken));
    chk("ras_empty", 32'(bus.ras_empty), 32'(m_stk.size() == 0));
    chk("ras_full", 32'(bus.ras_full), 32'(m_stk.size() == DEPTH));
    chk("err", 32'(bus.err), 32'(m_err));
  endtask

  task automatic model(input logic rs, st, j, b, input logic [1:0] m,
                       input logic z, ng, c, r, input logic [7:0] o);
    logic [31:0] p4, tgt;
    int signed   so;
    bit          cond, was_empty;
    if (rs) begin
      m_pc = 32'h0; m_taken = 0; m_err = 0; m_stk.delete();
      return;
    end
    if (st) return;
    p4 = m_pc + 32'd4;
    so = $signed(o);
    tgt = p4 + 32'(so * 4);
    case (m)
      2'd0: cond = z;
      2'd1: cond = !z;
      2'd2: cond = ng;
      default: cond = !ng;
    endcase
    was_empty = (m_stk.size() == 0);
    if (r && !was_empty) begin
      m_pc = m_stk.pop_back(); m_taken = 1;
    end else if (c) begin
      if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
      m_stk.push_back(p4);
      m_pc = tgt; m_taken = 1;
    end else if ((j && !b) || (b && !j && cond)) begin
      m_pc = tgt; m_taken = 1;
    end else begin
      m_pc = p4; m_taken = 0;
    end
    if (r && was_empty) m_err[0] = 1'b1;
    if (j && b && !c && !r) m_err[1] = 1'b1;
  endtask

  task automatic step(input logic rs, st, j, b, input logic [1:0] m,
                      input logic z, ng, c, r, input logic [7:0] o);
    reset = rs; bus.stall = st; bus.jump = j; bus.branch = b; bus.br_mode = m;
    bus.zero = z; bus.neg = ng; bus.call = c; bus.ret = r; bus.offset = o;
    model(rs, st, j, b, m, z, ng, c, r, o);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();  step(1,0,0,0,2'd0,0,0,0,0,8'h00); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,2'd0,0,0,0,0,8'h00);
  endtask

  initial begin
    bus.stall = 0; bus.jump = 0; bus.branch = 0; bus.br_mode = 0;
    bus.zero = 0; bus.neg = 0; bus.call = 0; bus.ret = 0; bus.offset = 0;
    m_pc = 0; m_taken = 0; m_err = 0;
    @(negedge clk);

    // Reset then sequential fetch
    do_reset();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_empty", 32'(bus.ras_empty), 32'd1);
    idle(1); chk("seq_4", bus.pc, 32'h4);
    idle(1); chk("seq_8", bus.pc, 32'h8);
    idle(1); chk("seq_c", bus.pc, 32'hC);
    chk("seq_taken", 32'(bus.taken), 32'd0);

    // BNE taken backwards, then not taken
    idle(1);
    step(0,0,0,1,2'b01,0,0,0,0,8'hFE);
    chk("bne_tk_pc", bus.pc, 32'h0C);
    chk("bne_tk_taken", 32'(bus.taken), 32'd1);
    do_reset(); idle(4);
    step(0,0,0,1,2'b01,1,0,0,0,8'hFE);
    chk("bne_nt_pc", bus.pc, 32'h14);

    // CALL then RET
    do_reset(); idle(16);
    step(0,0,0,0,2'd0,0,0,1,0,8'h10);
    chk("call_pc", bus.pc, 32'h84);
    step(0,0,0,0,2'd0,0,0,0,1,8'h00);
    chk("ret_pc", bus.pc, 32'h44);
    chk("ret_empty", 32'(bus.ras_empty), 32'd1);

    // Overflow: 5 calls, 4 LIFO returns, 5th underflows
    do_reset();
    for (int i = 0; i < 5; i++) step(0,0,0,0,2'd0,0,0,1,0,8'h00);
    chk("ovf_full", 32'(bus.ras_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0,0,0,0,2'd0,0,0,0,1,8'h00);
      chk("lifo_pc", bus.pc, 32'(20 - 4 * i));
    end
    step(0,0,0,0,2'd0,0,0,0,1,8'h00);
    chk("uflow_pc", bus.pc, 32'hC);
    chk("uflow_err", 32'(bus.err), 32'h1);

    // JUMP+BRANCH conflict, stall hold, reset under stall
    do_reset(); idle(8);
    step(0,0,1,1,2'd0,1,0,0,0,8'h40);
    chk("jb_pc", bus.pc, 32'h24);
    chk("jb_err", 32'(bus.err), 32'h2);
    for (int i = 0; i < 3; i++) step(0,1,1,0,2'd0,0,0,1,0,8'h40);
    chk("stall_pc", bus.pc, 32'h24);
    step(1,1,0,0,2'd0,0,0,0,0,8'h00);
    chk("rst_stall_pc", bus.pc, 32'h0);
    chk("rst_stall_err", 32'(bus.err), 32'h0);

    // Wrap: jump backwards from 0 to top of space, then increment wraps to 0
    step(0,0,1,0,2'd0,0,0,0,0,8'hFE);
    chk("wrap_top", bus.pc, 32'hFFFFFFFC);
    idle(1);
    chk("wrap_zero", bus.pc, 32'h0);
    chk("wrap_err", 32'(bus.err), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic rs, st, j, b, z, ng, c, r;
      logic [1:0] m;
      logic [7:0] o;
      rs = ($urandom_range(63) == 0);
      st = ($urandom_range(7) == 0);
      j  = ($urandom_range(3) == 0);
      b  = ($urandom_range(2) == 0);
      c  = ($urandom_range(4) == 0);
      r  = ($urandom_range(3) == 0);
      z  = 1'($urandom_range(1));
      ng = 1'($urandom_range(1));
      m  = 2'($urandom_range(3));
      o  = 8'($urandom_range(255));
      if (j && b) begin c = 0; r = 0; end
      if (c && r && m_stk.size() == 0) r = 0;
      step(rs, st, j, b, m, z, ng, c, r, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
